// File: rtl/serial_soc_pkg.sv
// Shared AXI-Lite response codes and channel FSM state types for the serial
// interface control-bus slaves.
package serial_soc_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } r_state_t;

endpackage

// File: rtl/reg_addr_decode.sv
// Combinational byte-address to register-index decode for the register bank;
// the two low address bits are ignored.
module reg_addr_decode
   import serial_soc_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          NUM_REGS   = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          IDX_W      = 4
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [IDX_W-1:0]      idx,
   output logic                  hit
);

   localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-3:0] NUM_W = (ADDR_WIDTH-2)'(NUM_REGS);

   logic [ADDR_WIDTH-3:0] word;

   // BASE is word aligned, so subtracting word addresses equals (addr - BASE) >> 2.
   always_comb begin
      word = addr[ADDR_WIDTH-1:2] - BASE[ADDR_WIDTH-1:2];
      hit  = (addr >= BASE) && (word < NUM_W);
      idx  = word[IDX_W-1:0];
   end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI-Lite slave holding NUM_REGS read/write registers with per-register write pulses.
// Define AXI_REG_DECERR_EN to answer unmapped accesses with DECERR instead of OKAY.
//
// state  | meaning
// W_IDLE | collecting AW and W into holding registers; commit once both held
// W_RESP | write response presented, waiting for bready
// R_IDLE | arready high, waiting for an AR handshake
// R_RESP | read data presented, waiting for rready
module axi_lite_reg_bank
   import serial_soc_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          NUM_REGS   = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     s_axi_awready,
   input  logic                     s_axi_awvalid,
   input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
   output logic                     s_axi_wready,
   input  logic                     s_axi_wvalid,
   input  logic [3:0]               s_axi_wstrb,
   input  logic [31:0]              s_axi_wdata,
   input  logic                     s_axi_bready,
   output logic                     s_axi_bvalid,
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_arready,
   input  logic                     s_axi_arvalid,
   input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
   input  logic                     s_axi_rready,
   output logic                     s_axi_rvalid,
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic [NUM_REGS*32-1:0]   reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI_REG_DECERR_EN
   localparam logic [1:0] MISS_RESP = RESP_DECERR;
`else
   localparam logic [1:0] MISS_RESP = RESP_OKAY;
`endif

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic [31:0]           regs [NUM_REGS];
   logic                  aw_held, w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  aw_hs, w_hs, ar_hs, w_commit;
   logic [IDX_W-1:0]      w_idx, r_idx;
   logic                  w_hit, r_hit;

   reg_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR),
      .IDX_W      (IDX_W)
   ) u_wr_decode (
      .addr (aw_addr_q),
      .idx  (w_idx),
      .hit  (w_hit)
   );

   reg_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR),
      .IDX_W      (IDX_W)
   ) u_rd_decode (
      .addr (s_axi_araddr),
      .idx  (r_idx),
      .hit  (r_hit)
   );

   assign aw_hs    = s_axi_awvalid && s_axi_awready;
   assign w_hs     = s_axi_wvalid && s_axi_wready;
   assign ar_hs    = s_axi_arvalid && s_axi_arready;
   assign w_commit = (w_state == W_IDLE) && aw_held && w_held;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
      assign reg_q[32*i +: 32] = regs[i];
   end

   // Write FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (w_commit) w_state_nxt = W_RESP;
         W_RESP:  if (s_axi_bready) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      s_axi_awready = (w_state == W_IDLE) && !aw_held;
      s_axi_wready  = (w_state == W_IDLE) && !w_held;
      s_axi_bvalid  = (w_state == W_RESP);
   end

   // Read FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (s_axi_arvalid) r_state_nxt = R_RESP;
         R_RESP:  if (s_axi_rready) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      s_axi_arready = (r_state == R_IDLE);
      s_axi_rvalid  = (r_state == R_RESP);
   end

   // AW/W holding registers and write response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         aw_addr_q   <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         s_axi_bresp <= RESP_OKAY;
      end else if (w_commit) begin
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         s_axi_bresp <= w_hit ? RESP_OKAY : MISS_RESP;
      end else begin
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
         end
         if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
      end
   end

   // Register storage; a read sampling on the commit edge sees the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (w_commit && w_hit) begin
            for (int b = 0; b < 4; b++) begin
               if (wstrb_q[b]) regs[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
            if (|wstrb_q) reg_wr_pulse[w_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_axi_rdata <= '0;
         s_axi_rresp <= RESP_OKAY;
      end else if (ar_hs) begin
         s_axi_rdata <= r_hit ? regs[r_idx] : '0;
         s_axi_rresp <= r_hit ? RESP_OKAY : MISS_RESP;
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed self-checking bench for axi_lite_reg_bank (default parameters, BASE_ADDR 0).
module tb_axi_lite_reg_bank;

   localparam int NUM_REGS = 16;
`ifdef AXI_REG_DECERR_EN
   localparam logic [1:0] EXP_MISS = 2'b11;
`else
   localparam logic [1:0] EXP_MISS = 2'b00;
`endif

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   awready, awvalid;
   logic [31:0]            awaddr;
   logic                   wready, wvalid;
   logic [3:0]             wstrb;
   logic [31:0]            wdata;
   logic                   bready, bvalid;
   logic [1:0]             bresp;
   logic                   arready, arvalid;
   logic [31:0]            araddr;
   logic                   rready, rvalid;
   logic [31:0]            rdata;
   logic [1:0]             rresp;
   logic [NUM_REGS*32-1:0] reg_q;
   logic [NUM_REGS-1:0]    reg_wr_pulse;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0]            exp_regs [NUM_REGS];
   logic [NUM_REGS*32-1:0] exp_q;

   always #5 clk = ~clk;

   axi_lite_reg_bank dut (
      .clk           (clk),
      .reset         (reset),
      .s_axi_awready (awready),
      .s_axi_awvalid (awvalid),
      .s_axi_awaddr  (awaddr),
      .s_axi_wready  (wready),
      .s_axi_wvalid  (wvalid),
      .s_axi_wstrb   (wstrb),
      .s_axi_wdata   (wdata),
      .s_axi_bready  (bready),
      .s_axi_bvalid  (bvalid),
      .s_axi_bresp   (bresp),
      .s_axi_arready (arready),
      .s_axi_arvalid (arvalid),
      .s_axi_araddr  (araddr),
      .s_axi_rready  (rready),
      .s_axi_rvalid  (rvalid),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .reg_q         (reg_q),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build_exp_q();
      for (int i = 0; i < NUM_REGS; i++) exp_q[32*i +: 32] = exp_regs[i];
   endtask

   task automatic test_reset();
      awvalid = 0; awaddr = '0; wvalid = 0; wstrb = '0; wdata = '0;
      bready = 0; arvalid = 0; araddr = '0; rready = 0;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
      #12;
      vectors++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
         miscompares++;
         $display("FAIL reset_handshake: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
      end
      vectors++;
      if ({bresp, rresp, rdata, reg_wr_pulse} !== '0 || reg_q !== '0) begin
         miscompares++;
         $display("FAIL reset_values: bresp %b rresp %b rdata %h pulse %h reg_q nonzero %b",
                  bresp, rresp, rdata, reg_wr_pulse, reg_q !== '0);
      end
      @(negedge clk);
      reset = 0;
      tick();
   endtask

   task automatic test_write_same_cycle();
      awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      vectors++;
      if ({awready, wready} !== 2'b11) begin
         miscompares++;
         $display("FAIL wsc_ready_before: got %b expected 11", {awready, wready});
      end
      tick();
      awvalid = 0; wvalid = 0;
      vectors++;
      if ({bvalid, awready, wready} !== 3'b000) begin
         miscompares++;
         $display("FAIL wsc_held: bvalid/awready/wready got %b expected 000", {bvalid, awready, wready});
      end
      tick();
      vectors++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         miscompares++;
         $display("FAIL wsc_bresp: bvalid %b bresp %b expected 1 00", bvalid, bresp);
      end
      vectors++;
      if (reg_q[2*32 +: 32] !== 32'hDEAD_BEEF || reg_wr_pulse !== 16'h0004) begin
         miscompares++;
         $display("FAIL wsc_reg2: reg %h pulse %h expected deadbeef 0004", reg_q[2*32 +: 32], reg_wr_pulse);
      end
      exp_regs[2] = 32'hDEAD_BEEF;
      bready = 1;
      tick();
      bready = 0;
      vectors++;
      if ({bvalid, awready, wready} !== 3'b011 || reg_wr_pulse !== '0) begin
         miscompares++;
         $display("FAIL wsc_after_b: bvalid/awready/wready %b pulse %h expected 011 0000",
                  {bvalid, awready, wready}, reg_wr_pulse);
      end
   endtask

   task automatic test_write_w_first();
      wvalid = 1; wdata = 32'h1122_3344; wstrb = 4'b0101;
      tick();
      wvalid = 0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (wready !== 1'b0 || bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wf_wait%0d: wready %b bvalid %b expected 0 0", i, wready, bvalid);
         end
         if (i < 2) tick();
      end
      awvalid = 1; awaddr = 32'h4;
      tick();
      awvalid = 0;
      tick();
      vectors++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || wready !== 1'b0) begin
         miscompares++;
         $display("FAIL wf_bresp: bvalid %b bresp %b wready %b expected 1 00 0", bvalid, bresp, wready);
      end
      vectors++;
      if (reg_q[1*32 +: 32] !== 32'h0022_0044 || reg_wr_pulse !== 16'h0002) begin
         miscompares++;
         $display("FAIL wf_reg1: reg %h pulse %h expected 00220044 0002", reg_q[1*32 +: 32], reg_wr_pulse);
      end
      exp_regs[1] = 32'h0022_0044;
      bready = 1;
      tick();
      bready = 0;
      vectors++;
      if (wready !== 1'b1) begin
         miscompares++;
         $display("FAIL wf_wready_back: got %b expected 1", wready);
      end
   endtask

   task automatic test_read_stall();
      arvalid = 1; araddr = 32'h8; rready = 0;
      tick();
      arvalid = 0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || rresp !== 2'b00 || arready !== 1'b0) begin
            miscompares++;
            $display("FAIL rs_hold%0d: rvalid %b rdata %h rresp %b arready %b expected 1 deadbeef 00 0",
                     i, rvalid, rdata, rresp, arready);
         end
         tick();
      end
      rready = 1;
      tick();
      rready = 0;
      vectors++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         miscompares++;
         $display("FAIL rs_done: rvalid %b arready %b expected 0 1", rvalid, arready);
      end
   endtask

   task automatic test_last_and_unaligned();
      awvalid = 1; awaddr = 32'h3F; wvalid = 1; wdata = 32'h0F0F_0F0F; wstrb = 4'hF;
      tick();
      awvalid = 0; wvalid = 0;
      tick();
      vectors++;
      if (bresp !== 2'b00 || reg_q[15*32 +: 32] !== 32'h0F0F_0F0F || reg_wr_pulse !== 16'h8000) begin
         miscompares++;
         $display("FAIL last_write: bresp %b reg15 %h pulse %h expected 00 0f0f0f0f 8000",
                  bresp, reg_q[15*32 +: 32], reg_wr_pulse);
      end
      exp_regs[15] = 32'h0F0F_0F0F;
      bready = 1;
      tick();
      bready = 0;
      arvalid = 1; araddr = 32'h3E;
      tick();
      arvalid = 0;
      vectors++;
      if (rvalid !== 1'b1 || rdata !== 32'h0F0F_0F0F || rresp !== 2'b00) begin
         miscompares++;
         $display("FAIL last_read: rvalid %b rdata %h rresp %b expected 1 0f0f0f0f 00", rvalid, rdata, rresp);
      end
      rready = 1;
      tick();
      rready = 0;
   endtask

   task automatic test_zero_strobe();
      awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'hFFFF_FFFF; wstrb = 4'h0;
      tick();
      awvalid = 0; wvalid = 0;
      tick();
      vectors++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_wr_pulse !== '0 || reg_q[2*32 +: 32] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL zero_strb: bvalid %b bresp %b pulse %h reg2 %h expected 1 00 0000 deadbeef",
                  bvalid, bresp, reg_wr_pulse, reg_q[2*32 +: 32]);
      end
      bready = 1;
      tick();
      bready = 0;
   endtask

   task automatic test_miss();
      awvalid = 1; awaddr = 32'h40; wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF;
      tick();
      awvalid = 0; wvalid = 0;
      tick();
      build_exp_q();
      vectors++;
      if (bvalid !== 1'b1 || bresp !== EXP_MISS || reg_wr_pulse !== '0) begin
         miscompares++;
         $display("FAIL miss_bresp: bvalid %b bresp %b pulse %h expected 1 %b 0000", bvalid, bresp, reg_wr_pulse, EXP_MISS);
      end
      vectors++;
      if (reg_q !== exp_q) begin
         miscompares++;
         $display("FAIL miss_regs: reg_q %h expected %h", reg_q, exp_q);
      end
      bready = 1;
      tick();
      bready = 0;
      arvalid = 1; araddr = 32'h40;
      tick();
      arvalid = 0;
      vectors++;
      if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== EXP_MISS) begin
         miscompares++;
         $display("FAIL miss_read: rvalid %b rdata %h rresp %b expected 1 00000000 %b", rvalid, rdata, rresp, EXP_MISS);
      end
      rready = 1;
      tick();
      rready = 0;
   endtask

   task automatic test_simul_rw();
      awvalid = 1; awaddr = 32'h0; wvalid = 1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
      tick();
      awvalid = 0; wvalid = 0;
      arvalid = 1; araddr = 32'h0;
      tick();
      arvalid = 0;
      vectors++;
      if ({bvalid, rvalid} !== 2'b11 || rdata !== 32'h0 || reg_q[31:0] !== 32'hA5A5_A5A5) begin
         miscompares++;
         $display("FAIL simul_same_edge: bvalid/rvalid %b rdata %h reg0 %h expected 11 00000000 a5a5a5a5",
                  {bvalid, rvalid}, rdata, reg_q[31:0]);
      end
      exp_regs[0] = 32'hA5A5_A5A5;
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      vectors++;
      if ({bvalid, rvalid} !== 2'b00) begin
         miscompares++;
         $display("FAIL simul_both_done: got %b expected 00", {bvalid, rvalid});
      end
      arvalid = 1; araddr = 32'h0;
      tick();
      arvalid = 0;
      vectors++;
      if (rvalid !== 1'b1 || rdata !== 32'hA5A5_A5A5) begin
         miscompares++;
         $display("FAIL simul_reread: rvalid %b rdata %h expected 1 a5a5a5a5", rvalid, rdata);
      end
      rready = 1;
      tick();
      rready = 0;
   endtask

   task automatic test_reset_mid();
      awvalid = 1; awaddr = 32'h4; wvalid = 1; wdata = 32'h0000_0099; wstrb = 4'hF;
      arvalid = 1; araddr = 32'h8;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      tick();
      vectors++;
      if ({bvalid, rvalid} !== 2'b11) begin
         miscompares++;
         $display("FAIL rm_pending: bvalid/rvalid %b expected 11", {bvalid, rvalid});
      end
      #2 reset = 1;
      #1;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
      vectors++;
      if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
         miscompares++;
         $display("FAIL rm_handshake: bvalid/rvalid/awready/wready/arready %b expected 00111",
                  {bvalid, rvalid, awready, wready, arready});
      end
      vectors++;
      if (reg_q !== '0 || reg_wr_pulse !== '0 || rdata !== '0 || {bresp, rresp} !== 4'b0000) begin
         miscompares++;
         $display("FAIL rm_values: reg_q zero %b pulse %h rdata %h bresp %b rresp %b expected 1 0000 0 00 00",
                  reg_q === '0, reg_wr_pulse, rdata, bresp, rresp);
      end
      #2 reset = 0;
      tick();
      // A held AW must be discarded by reset: a lone W afterwards cannot complete.
      awvalid = 1; awaddr = 32'h0;
      tick();
      awvalid = 0;
      vectors++;
      if (awready !== 1'b0) begin
         miscompares++;
         $display("FAIL rm_aw_held: awready %b expected 0", awready);
      end
      #2 reset = 1;
      #2 reset = 0;
      tick();
      vectors++;
      if (awready !== 1'b1) begin
         miscompares++;
         $display("FAIL rm_aw_cleared: awready %b expected 1", awready);
      end
      wvalid = 1; wdata = 32'h0000_0055; wstrb = 4'hF;
      tick();
      wvalid = 0;
      tick();
      tick();
      vectors++;
      if (bvalid !== 1'b0 || reg_q[31:0] !== 32'h0 || awready !== 1'b1) begin
         miscompares++;
         $display("FAIL rm_no_stale_aw: bvalid %b reg0 %h awready %b expected 0 00000000 1", bvalid, reg_q[31:0], awready);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_same_cycle();
      test_write_w_first();
      test_read_stall();
      test_last_and_unaligned();
      test_zero_strobe();
      test_miss();
      test_simul_rw();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_lite_reg_bank.md
# axi_lite_reg_bank

AXI-Lite slave register bank that terminates the control bus driven by the serial interface's AXI-Lite master. It holds NUM_REGS 32-bit read/write registers at consecutive word addresses starting at BASE_ADDR, and exposes their contents and per-register write pulses to SoC logic. It accepts independent address and data arrival on the write channel, one outstanding write and one outstanding read at a time.

## Interface
- ADDR_WIDTH, 32, AXI address width
- NUM_REGS, 16, number of 32-bit registers (1..256)
- BASE_ADDR, 32'h0000_0000, byte address of register 0; word aligned
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_axi_awready / s_axi_awvalid / s_axi_awaddr  out / in / in  1 / 1 / ADDR_WIDTH  write address channel
- s_axi_wready / s_axi_wvalid / s_axi_wstrb / s_axi_wdata  out / in / in / in  1 / 1 / 4 / 32  write data channel
- s_axi_bready / s_axi_bvalid / s_axi_bresp  in / out / out  1 / 1 / 2  write response channel
- s_axi_arready / s_axi_arvalid / s_axi_araddr  out / in / in  1 / 1 / ADDR_WIDTH  read address channel
- s_axi_rready / s_axi_rvalid / s_axi_rdata / s_axi_rresp  in / out / out / out  1 / 1 / 32 / 2  read data channel
- reg_q  out  NUM_REGS*32  register contents, register i at bits [32*i+:32]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse, bit i set the cycle after register i is written

## Operation
- Decode: idx = (addr - BASE_ADDR) >> 2; hit when addr >= BASE_ADDR and idx < NUM_REGS; addr[1:0] ignored.
- Write FSM states W_IDLE, W_RESP. In W_IDLE, AW and W each latch into a one-entry holding register; awready = ~aw_held, wready = ~w_held. Both may handshake same cycle or in either order.
- When both held (W_IDLE): on hit, each byte lane with wstrb set is written; reg_wr_pulse[idx] set next cycle if wstrb != 0. Miss: no register changes. Enter W_RESP, holdings cleared, bvalid=1, bresp = OKAY on hit else miss response.
- W_RESP: awready=wready=0; stay until bvalid && bready, then W_IDLE.
- Read FSM states R_IDLE, R_RESP. arready = (state == R_IDLE). On AR handshake: rdata = hit ? register[idx] : 0, rresp = OKAY or miss response, enter R_RESP with rvalid=1. Leave on rvalid && rready.
- rdata/rresp/bresp stable while valid is high.
- Read and write channels fully independent; both may complete in the same cycle.

## Timing
- Reset (async assert, sync-safe deassert): all registers 0, reg_q 0, reg_wr_pulse 0, bvalid 0, rvalid 0, bresp/rresp 2'b00, rdata 0, awready/wready/arready 1, both FSMs idle, holdings empty.
- Write: last of AW/W handshakes at edge N → register updated and bvalid high after edge N+1; reg_wr_pulse high cycle N+1..N+2. Next AW/W acceptable the cycle after B handshake.
- Read: AR handshake at edge N → rvalid/rdata valid after edge N. Back-to-back read min period 2 cycles.
- Read vs write to same register committing on the same edge: read returns the pre-write value.
- AW held with W absent: awready stays 0 indefinitely; no timeout.
- Reset mid-transaction: outstanding responses dropped, held AW/W discarded.

## Configuration
- AXI_REG_DECERR_EN defined: miss response = DECERR (2'b11) for reads and writes.
- Not defined: miss response = OKAY (2'b00); miss writes silently dropped, miss reads return 0.

## Structure
- Package serial_soc_pkg: AXI response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; write/read FSM state enums.
- Sub-module reg_addr_decode (combinational): addr → idx, hit; instanced twice (write, read).

## Test plan
- AW+W same cycle, addr BASE+8, wdata 32'hDEADBEEF, wstrb 4'hF → bvalid after 1 cycle, bresp 00, reg_q[2] = DEADBEEF, reg_wr_pulse = 1<<2 for one cycle.
- W 3 cycles before AW (addr BASE+4, wdata 32'h1122_3344, wstrb 4'b0101) over reg 1 = 0 → reg 1 = 32'h0022_0044; wready 0 after W accepted until B handshake.
- Read BASE+8 with rready held low 5 cycles → rvalid, rdata DEADBEEF stable throughout; arready 0 until handshake.
- Address BASE+4*NUM_REGS write and read → no reg_q change, rdata 0, resp 2'b11 with AXI_REG_DECERR_EN, 2'b00 without.
- Simultaneous write 32'hA5A5A5A5 and read of reg 0 (previously 0) committing same edge → rdata 0, subsequent read A5A5A5A5.
- Assert reset while bvalid and rvalid pending → both drop immediately, reg_q 0, readys 1.
